// File: rtl/csa_item_ram.sv
// Multi-channel CSA item RAM: byte-stuffed through command registers, streamed round-robin as fixed-width items.
// Optional macro CSA_ITEM_RAM_DEBUG_EN adds the raw-byte readback window at DEBUG_BASE.
module csa_item_ram #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int OPT_MEM_ADDR_BITS  = 3,
  parameter int ITEM_BYTES         = 6,
  parameter int ITEM_NUM           = 16,
  parameter int CHANNEL_NUM        = 2,
  parameter int DEBUG_BASE         = 256,
  localparam int CH_BITS = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            rst,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic                            wen,
  input  logic [OPT_MEM_ADDR_BITS:0]      waddr,
  input  logic                            ren,
  input  logic [12:0]                     raddr,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   rdata,
  output logic [ITEM_BYTES*8-1:0]         item_out,
  output logic [CH_BITS-1:0]              item_ch,
  output logic                            item_valid,
  input  logic                            item_ready,
  output logic                            ready,
  output logic                            err
);

  localparam int W        = C_S_AXI_DATA_WIDTH;
  localparam int NB       = W / 8;
  localparam int WA       = OPT_MEM_ADDR_BITS + 1;
  localparam int CH_BYTES = ITEM_NUM * ITEM_BYTES;
  localparam int TOTAL    = CH_BYTES * CHANNEL_NUM;
  localparam int AW       = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int CUR_W    = $clog2(CH_BYTES + 1);
  localparam int IDX_W    = (ITEM_NUM > 1) ? $clog2(ITEM_NUM) : 1;

  localparam logic [WA-1:0] CMD_REQ   = WA'(0);
  localparam logic [WA-1:0] CMD_DATA  = WA'(1);
  localparam logic [WA-1:0] CMD_FIN   = WA'(2);
  localparam logic [WA-1:0] CMD_CLEAR = WA'(3);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STUFF  = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t                   state_r, state_nxt;
  logic [CH_BITS-1:0]       cur_ch_r, cur_ch_nxt;
  logic [CUR_W-1:0]         cursor_r, cursor_nxt, acc_s;
  logic [CHANNEL_NUM-1:0]   loaded_r, loaded_nxt;
  logic                     err_r, err_nxt, ready_r;
  logic [7:0]               mem [TOTAL];
  logic [NB-1:0]            lane_we_s;
  logic [AW-1:0]            lane_addr_s [NB];
  logic                     data_ovf_s;
  logic                     cmd_req_s, cmd_data_s, cmd_fin_s, cmd_clr_s, req_ok_s, data_act_s;
  logic [CH_BITS-1:0]       req_ch_s;
  logic                     arm_r, stay_stream_s, load_item_s;
  logic [CH_BITS-1:0]       rd_ch_r;
  logic [IDX_W-1:0]         rd_idx_r;
  logic [ITEM_BYTES*8-1:0]  fetch_s;
  logic [W-1:0]             status_s, rd_word_s;

  assign req_ch_s   = S_AXI_WDATA[CH_BITS-1:0];
  assign cmd_req_s  = wen && (waddr == CMD_REQ);
  assign cmd_data_s = wen && (waddr == CMD_DATA);
  assign cmd_fin_s  = wen && (waddr == CMD_FIN);
  assign cmd_clr_s  = wen && (waddr == CMD_CLEAR);
  assign req_ok_s   = cmd_req_s && (32'(req_ch_s) < 32'(CHANNEL_NUM));
  assign data_act_s = cmd_data_s && (state_r == S_STUFF);

  // Place enabled bytes, lane 0 first, at consecutive cursor positions; drop anything past the channel end.
  always_comb begin
    acc_s      = cursor_r;
    data_ovf_s = 1'b0;
    lane_we_s  = '0;
    for (int l = 0; l < NB; l++) begin
      lane_addr_s[l] = '0;
      if (data_act_s && S_AXI_WSTRB[l]) begin
        if (32'(acc_s) < 32'(CH_BYTES)) begin
          lane_we_s[l]   = 1'b1;
          lane_addr_s[l] = AW'(32'(cur_ch_r) * 32'(CH_BYTES) + 32'(acc_s));
          acc_s          = acc_s + CUR_W'(1);
        end else begin
          data_ovf_s = 1'b1;
        end
      end else begin
        lane_addr_s[l] = '0;
      end
    end
  end

  // Command decode and next-state logic.
  always_comb begin
    state_nxt  = state_r;
    err_nxt    = err_r;
    loaded_nxt = loaded_r;
    cur_ch_nxt = cur_ch_r;
    cursor_nxt = cursor_r;
    if (cmd_clr_s) begin
      state_nxt  = S_IDLE;
      err_nxt    = 1'b0;
      loaded_nxt = '0;
    end else if (cmd_req_s) begin
      if (req_ok_s) begin
        cur_ch_nxt           = req_ch_s;
        cursor_nxt           = '0;
        loaded_nxt[req_ch_s] = 1'b0;
        state_nxt            = S_STUFF;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (data_act_s) begin
      cursor_nxt = acc_s;
      err_nxt    = err_r | data_ovf_s;
    end else if (cmd_fin_s && (state_r == S_STUFF)) begin
      if (32'(cursor_r) == 32'(CH_BYTES)) begin
        loaded_nxt[cur_ch_r] = 1'b1;
      end else begin
        err_nxt = 1'b1;
      end
      state_nxt = S_IDLE;
    end else if ((state_r == S_IDLE) && (&loaded_r)) begin
      state_nxt = S_STREAM;
    end else begin
      state_nxt = state_r;
    end
  end

  // Control state register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) begin
      state_r  <= S_IDLE;
      cur_ch_r <= '0;
      cursor_r <= '0;
      loaded_r <= '0;
      err_r    <= 1'b0;
      ready_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      cur_ch_r <= cur_ch_nxt;
      cursor_r <= cursor_nxt;
      loaded_r <= loaded_nxt;
      err_r    <= err_nxt;
      ready_r  <= (state_nxt == S_STREAM);
    end
  end

  assign ready = ready_r;
  assign err   = err_r;

  // Byte storage; deliberately not cleared by reset.
  always_ff @(posedge S_AXI_ACLK) begin
    for (int l = 0; l < NB; l++) begin
      if (lane_we_s[l]) begin
        mem[lane_addr_s[l]] <= S_AXI_WDATA[8*l +: 8];
      end
    end
  end

  // Gather the item at the read pointer.
  always_comb begin
    fetch_s = '0;
    for (int b = 0; b < ITEM_BYTES; b++) begin
      fetch_s[8*b +: 8] = mem[AW'((32'(rd_ch_r) * 32'(ITEM_NUM) + 32'(rd_idx_r)) * 32'(ITEM_BYTES) + 32'(b))];
    end
  end

  // arm_r delays the first fetch one cycle after entering streaming; any command leaving it drops valid.
  assign stay_stream_s = (state_r == S_STREAM) && (state_nxt == S_STREAM);
  assign load_item_s   = arm_r && stay_stream_s && (!item_valid || item_ready);

  // Item output register and round-robin read pointer.
  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) begin
      arm_r      <= 1'b0;
      item_valid <= 1'b0;
      item_out   <= '0;
      item_ch    <= '0;
      rd_ch_r    <= '0;
      rd_idx_r   <= '0;
    end else begin
      arm_r <= stay_stream_s;
      if (!stay_stream_s) begin
        item_valid <= 1'b0;
        rd_ch_r    <= '0;
        rd_idx_r   <= '0;
      end else if (load_item_s) begin
        item_out   <= fetch_s;
        item_ch    <= rd_ch_r;
        item_valid <= 1'b1;
        if (32'(rd_ch_r) == 32'(CHANNEL_NUM - 1)) begin
          rd_ch_r  <= '0;
          rd_idx_r <= (32'(rd_idx_r) == 32'(ITEM_NUM - 1)) ? '0 : rd_idx_r + IDX_W'(1);
        end else begin
          rd_ch_r <= rd_ch_r + CH_BITS'(1);
        end
      end else begin
        item_valid <= item_valid;
      end
    end
  end

  // Debug readback decode.
  always_comb begin
    status_s                  = '0;
    status_s[W-1]             = err_r;
    status_s[CHANNEL_NUM+1:2] = loaded_r;
    status_s[1:0]             = state_r;
    rd_word_s                 = '0;
    if (raddr == 13'd0) begin
      rd_word_s = status_s;
    end else if (raddr == 13'd1) begin
      rd_word_s = W'(cursor_r);
`ifdef CSA_ITEM_RAM_DEBUG_EN
    end else if (32'(raddr) >= 32'(DEBUG_BASE)) begin
      for (int b = 0; b < NB; b++) begin
        if ((32'(raddr) - 32'(DEBUG_BASE)) * 32'(NB) + 32'(b) < 32'(TOTAL)) begin
          rd_word_s[8*b +: 8] = mem[AW'((32'(raddr) - 32'(DEBUG_BASE)) * 32'(NB) + 32'(b))];
        end else begin
          rd_word_s[8*b +: 8] = 8'h00;
        end
      end
`endif
    end else begin
      rd_word_s = '0;
    end
  end

  // Registered read data, held while ren is low.
  always_ff @(posedge S_AXI_ACLK) begin
    if (rst) begin
      rdata <= '0;
    end else if (ren) begin
      rdata <= rd_word_s;
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: tb/tb_csa_item_ram.sv
// Directed bench for csa_item_ram (2 channels, 2 items of 6 bytes): loading, streaming, stalls, errors, debug reads.
module tb_csa_item_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        wen;
  logic [3:0]  waddr;
  logic        ren;
  logic [12:0] raddr;
  logic [31:0] rdata;
  logic [47:0] item_out;
  logic [0:0]  item_ch;
  logic        item_valid;
  logic        item_ready;
  logic        ready;
  logic        err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [47:0] out;
    logic        ch;
  } item_t;

  typedef struct {
    logic [12:0] addr;
    logic [31:0] exp;
  } rd_t;

  item_t seq [4];
  rd_t   rtab [6];

  always #5 clk = ~clk;

  csa_item_ram #(
    .C_S_AXI_DATA_WIDTH(32),
    .OPT_MEM_ADDR_BITS(3),
    .ITEM_BYTES(6),
    .ITEM_NUM(2),
    .CHANNEL_NUM(2),
    .DEBUG_BASE(256)
  ) dut (
    .S_AXI_ACLK(clk),
    .rst(rst),
    .S_AXI_WSTRB(wstrb),
    .S_AXI_WDATA(wdata),
    .wen(wen),
    .waddr(waddr),
    .ren(ren),
    .raddr(raddr),
    .rdata(rdata),
    .item_out(item_out),
    .item_ch(item_ch),
    .item_valid(item_valid),
    .item_ready(item_ready),
    .ready(ready),
    .err(err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    wen = 1'b1; waddr = a; wdata = d; wstrb = s;
    step();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [12:0] a, output logic [31:0] d);
    ren = 1'b1; raddr = a;
    step();
    ren = 1'b0;
    d = rdata;
  endtask

  task automatic load_ch(input logic [31:0] ch, input logic [31:0] base);
    wr(4'd0, ch, 4'hF);
    for (int k = 0; k < 3; k++) wr(4'd1, base + 32'h04040404 * 32'(k), 4'hF);
    wr(4'd2, 32'd0, 4'hF);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!item_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    logic [31:0] d;
    int n;

    seq[0] = '{out: 48'h050403020100, ch: 1'b0};
    seq[1] = '{out: 48'h151413121110, ch: 1'b1};
    seq[2] = '{out: 48'h0b0a09080706, ch: 1'b0};
    seq[3] = '{out: 48'h1b1a19181716, ch: 1'b1};
    rtab[0] = '{addr: 13'd0,   exp: 32'h0000000E};
    rtab[1] = '{addr: 13'd2,   exp: 32'h00000000};
`ifdef CSA_ITEM_RAM_DEBUG_EN
    rtab[2] = '{addr: 13'd256, exp: 32'h03020100};
    rtab[3] = '{addr: 13'd259, exp: 32'h13121110};
`else
    rtab[2] = '{addr: 13'd256, exp: 32'h00000000};
    rtab[3] = '{addr: 13'd259, exp: 32'h00000000};
`endif
    rtab[4] = '{addr: 13'd262, exp: 32'h00000000};
    rtab[5] = '{addr: 13'd1,   exp: 32'h0000000C};

    rst = 1'b1; wen = 1'b0; waddr = 4'd0; wdata = 32'd0; wstrb = 4'd0;
    ren = 1'b0; raddr = 13'd0; item_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 64'(item_valid), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_item", 64'(item_out), 64'd0);

    // Scenario 1: full load then free-running stream.
    load_ch(32'd0, 32'h03020100);
    load_ch(32'd1, 32'h13121110);
    step();
    chk("load_ready", 64'(ready), 64'd1);
    chk("load_err", 64'(err), 64'd0);
    wait_valid(n);
    chk("first_valid_lat", 64'(n), 64'd2);
    item_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("stream_valid", 64'(item_valid), 64'd1);
      chk("stream_ch", 64'(item_ch), 64'(seq[i % 4].ch));
      chk("stream_out", 64'(item_out), 64'(seq[i % 4].out));
      step();
    end
    for (int i = 0; i < 6; i++) begin
      rd(rtab[i].addr, d);
      chk("read_tab", 64'(d), 64'(rtab[i].exp));
    end
    step();
    chk("rdata_hold", 64'(rdata), 64'(rtab[5].exp));

    // Reset mid-stream, then reload with a stalled consumer.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 64'(item_valid), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd0);
    rd(13'd0, d);
    chk("mid_rst_status", 64'(d), 64'd0);
    item_ready = 1'b0;
    load_ch(32'd0, 32'h03020100);
    load_ch(32'd1, 32'h13121110);
    step();
    wait_valid(n);
    chk("reload_valid_seen", 64'(item_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 64'(item_valid), 64'd1);
      chk("stall_ch", 64'(item_ch), 64'd0);
      chk("stall_out", 64'(item_out), 64'(seq[0].out));
      step();
    end
    item_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("resume_valid", 64'(item_valid), 64'd1);
      chk("resume_out", 64'(item_out), 64'(seq[i].out));
      step();
    end

    // CLEAR while streaming withdraws valid.
    wr(4'd3, 32'd0, 4'hF);
    chk("clear_valid", 64'(item_valid), 64'd0);
    chk("clear_ready", 64'(ready), 64'd0);
    item_ready = 1'b0;

    // Short load sets err.
    wr(4'd0, 32'd0, 4'hF);
    wr(4'd1, 32'h03020100, 4'hF);
    wr(4'd1, 32'h07060504, 4'hF);
    wr(4'd2, 32'd0, 4'hF);
    chk("short_err", 64'(err), 64'd1);
    step();
    chk("short_ready", 64'(ready), 64'd0);
    rd(13'd0, d);
    chk("short_status", 64'(d), 64'h80000000);
    wr(4'd3, 32'd0, 4'hF);
    chk("clear_err", 64'(err), 64'd0);

    // Partial strobe, then overflow past the channel end.
    wr(4'd0, 32'd1, 4'hF);
    wr(4'd1, 32'hAAAA5555, 4'h3);
    rd(13'd1, d);
    chk("strb_cursor", 64'(d), 64'd2);
    chk("strb_err", 64'(err), 64'd0);
    wr(4'd1, 32'h03020100, 4'hF);
    wr(4'd1, 32'h07060504, 4'hF);
    wr(4'd1, 32'h0b0a0908, 4'hF);
    chk("ovf_err", 64'(err), 64'd1);
    wr(4'd2, 32'd0, 4'hF);
    rd(13'd0, d);
    chk("ovf_status", 64'(d), 64'h80000008);
    rd(13'd1, d);
    chk("ovf_cursor", 64'(d), 64'd12);
    rd(13'd259, d);
`ifdef CSA_ITEM_RAM_DEBUG_EN
    chk("ovf_bytes", 64'(d), 64'h01005555);
`else
    chk("ovf_bytes", 64'(d), 64'h0);
`endif
    chk("ovf_ready", 64'(ready), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csa_item_ram.md
Name: csa_item_ram

Overview:
- Parametrised multi-channel successor of the CSA key/data stuffing RAM.
- Software loads byte items per channel through AXI-lite register writes using a REQ_STUFF / STUFFING_DATA / FIN_STUFF command sequence.
- Once every channel is loaded, the block streams fixed-width items round-robin over a valid/ready handshake to the CSA datapath.
- A debug readback window exposes the status and the raw stored bytes.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; multiple of 8.
OPT_MEM_ADDR_BITS, 3, waddr is OPT_MEM_ADDR_BITS+1 bits.
ITEM_BYTES, 6, bytes per output item.
ITEM_NUM, 16, items per channel.
CHANNEL_NUM, 2, channel count, >=1; CH_BITS = max(1, clog2(CHANNEL_NUM)).
DEBUG_BASE, 256, first raddr of the raw-byte debug window.

Ports:
S_AXI_ACLK  in  1  sole clock, rising edge.
rst  in  1  synchronous, active-high reset.
S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  byte enables for wen.
S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
wen  in  1  write strobe, single cycle per write.
waddr  in  OPT_MEM_ADDR_BITS+1  command register select.
ren  in  1  debug read strobe.
raddr  in  13  debug read address.
rdata  out  C_S_AXI_DATA_WIDTH  registered read data.
item_out  out  ITEM_BYTES*8  current item; byte 0 at [7:0].
item_ch  out  CH_BITS  channel of item_out.
item_valid  out  1  item_out valid.
item_ready  in  1  consumer accepts.
ready  out  1  all channels loaded, streaming enabled.
err  out  1  sticky load error.

Behaviour:
- Reset (sync, high): state=S_IDLE; loaded flags, cursor, err, ready, item_valid, item_ch, item index, rdata, item_out all 0. Storage contents are not cleared.
- Commands on wen, decoded on waddr:
  - 0 REQ_STUFF: cur_ch=WDATA[CH_BITS-1:0]; cursor=0; clear loaded[cur_ch]; state=S_STUFF. A channel index >= CHANNEL_NUM sets err and leaves state unchanged.
  - 1 STUFFING_DATA: only acted on in S_STUFF. Enabled bytes, lane 0 first, are appended at cur_ch base + cursor; cursor advances by the popcount of WSTRB. Bytes beyond ITEM_NUM*ITEM_BYTES are dropped and set err.
  - 2 FIN_STUFF: only acted on in S_STUFF. If cursor == ITEM_NUM*ITEM_BYTES, set loaded[cur_ch]; otherwise set err. Either way, state=S_IDLE.
  - 3 CLEAR: clears all loaded flags and err; state=S_IDLE.
  - Other waddr values: ignored.
- State machine: S_IDLE -> S_STUFF (REQ_STUFF) -> S_IDLE (FIN_STUFF or CLEAR).
  - S_IDLE -> S_STREAM when all loaded flags are 1; ready=1 while in S_STREAM.
  - S_STREAM -> S_STUFF on REQ_STUFF; S_STREAM -> S_IDLE on CLEAR.
- Streaming:
  - Order: ch0 item0, ch1 item0, ..., ch(N-1) item0, ch0 item1, and so on. Item index wraps from ITEM_NUM-1 to 0 and streaming is continuous.
  - First item_valid is asserted 2 cycles after entering S_STREAM (registered storage read).
  - item_out and item_ch hold stable while item_valid && !item_ready.
  - A transfer occurs on item_valid && item_ready. The next item is presented the following cycle, giving full throughput of 1 item/cycle.
- Leaving S_STREAM (REQ_STUFF, CLEAR, rst): item_valid=0 the next cycle regardless of item_ready. This is the only permitted valid withdrawal. Re-entering S_STREAM restarts at ch0 item0.
- Debug reads (1-cycle latency, rdata holds when ren=0):
  - raddr 0: status {err at bit 31, loaded flags at [CHANNEL_NUM+1:2], state at [1:0]}.
  - raddr 1: cursor.
  - raddr DEBUG_BASE+k: flattened storage bytes 4k..4k+3, little endian.
  - Any other raddr, or beyond storage: 0.
- Simultaneous wen and ren: both serviced; a read returns pre-write contents.
- Simultaneous command and stream handshake: the handshake completes; the command takes effect in the same cycle.
- err is sticky until CLEAR or rst.

Optional Feature:
- CSA_ITEM_RAM_DEBUG_EN defined: the raw-byte window at DEBUG_BASE is present.
- Undefined: only raddr 0/1 decode, all other reads return 0, and no storage read port is used for debug.

Test Plan:
- CHANNEL_NUM=2, ITEM_NUM=2, ITEM_BYTES=6. Load ch0 with 0x03020100, 0x07060504, 0x0b0a0908, and ch1 with 0x13121110, 0x17161514, 0x1b1a1918; WSTRB=0xF, each followed by FIN.
  -> ready=1, err=0.
  -> With item_ready=1: item_out 0x050403020100 ch0, 0x151413121110 ch1, 0x0b0a09080706 ch0, 0x1b1a19181716 ch1, then repeats.
- Same load, item_ready=0 for 5 cycles after first valid -> item_out=0x050403020100, item_ch=0, item_valid=1 stable throughout; then one transfer per cycle once item_ready=1.
- Load ch0 with only 2 words, then FIN -> err=1, loaded[0]=0, ready stays 0; status read bit31=1; CLEAR -> err=0.
- STUFFING_DATA 0xAAAA5555 with WSTRB=0x3 -> bytes 0x55,0x55 appended; raddr 1 reads 2.
- Debug (macro on), after scenario 1: ren with raddr=256 -> rdata=0x03020100 next cycle; raddr=259 -> 0x13121110; raddr=262 -> 0.
- rst pulse mid-stream -> next cycle item_valid=0, ready=0, status reads 0; after reload, streaming restarts at ch0 item0.
